// File: rtl/matrix_load_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_load_seq
// Purpose  : Sequences one 12-word operand load into a downstream demux.
//            Words 0..3 go to the square-matrix slots on data_out1/sel1.
//            Words 4..10 go to the other slots on data_out2/sel2. Word 11
//            also goes on data_out2 but is selected with sel1=7, because the
//            sink routes that code from its second data input. Each accepted
//            word is presented for exactly one cycle after its accept edge.
//            Otherwise both selects sit at the idle code 3'b110.
// Revision : 1.0 - initial release
//
// Ports    : clk          sole clock, rising edge
//            rst_n        synchronous active-low reset
//            start        begins a load when sampled high in IDLE
//            in_valid     upstream word valid
//            in_data      upstream operand word [15:0]
//            in_ready     word accepted this cycle when in_valid is also high
//            data_out1    demux first data input [15:0]
//            data_out2    demux second data input [15:0]
//            sel1, sel2   demux select codes [2:0]
//            busy         high from load start until DONE is exited
//            done         one-cycle pulse after the 12th word is presented
//            timeout_err  sticky idle-timeout flag
//
// Config   : SEQ_TIMEOUT_EN - when defined, an 8-bit idle counter aborts a
//            stalled load after 255 consecutive in_valid=0 cycles. When it is
//            undefined, timeout_err is tied low and the block waits forever.
// ============================================================================
module matrix_load_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic [15:0] data_out1,
    output logic [15:0] data_out2,
    output logic [2:0]  sel1,
    output logic [2:0]  sel2,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    localparam logic [2:0] C_SEL_IDLE = 3'b110;
    localparam logic [2:0] C_SEL_HIGH = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOAD_X = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    // Set by the accept of word 11. It holds LOAD_X for the presentation
    // cycle so that DONE follows the presented word rather than coinciding
    // with it.
    logic        last_q, last_d;
    logic [15:0] dout1_q, dout1_d;
    logic [15:0] dout2_q, dout2_d;
    logic [2:0]  sel1_q, sel1_d;
    logic [2:0]  sel2_q, sel2_d;
    logic        in_load;
    logic        accept;

`ifdef SEQ_TIMEOUT_EN
    logic [7:0]  idle_q, idle_d;
    logic        terr_q, terr_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b0;
            dout1_q <= 16'd0;
            dout2_q <= 16'd0;
            sel1_q  <= C_SEL_IDLE;
            sel2_q  <= C_SEL_IDLE;
`ifdef SEQ_TIMEOUT_EN
            idle_q  <= 8'd0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            sel1_q  <= sel1_d;
            sel2_q  <= sel2_d;
`ifdef SEQ_TIMEOUT_EN
            idle_q  <= idle_d;
            terr_q  <= terr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        // Selects fall back to idle unless a word is accepted this cycle.
        sel1_d  = C_SEL_IDLE;
        sel2_d  = C_SEL_IDLE;
`ifdef SEQ_TIMEOUT_EN
        idle_d  = idle_q;
        terr_d  = terr_q;
`endif

        in_load  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                   (state_q == S_LOAD_X);
        in_ready = in_load && !last_q;
        accept   = in_valid && in_ready;
        busy     = in_load || (state_q == S_DONE);
        done     = (state_q == S_DONE);

        // Slot decode of the accepted word.
        if (accept) begin
            if (cnt_q < 4'd4) begin
                dout1_d = in_data;
                sel1_d  = cnt_q[2:0];
            end else if (cnt_q < 4'd10) begin
                dout2_d = in_data;
                sel2_d  = 3'(cnt_q - 4'd4);
            end else if (cnt_q == 4'd10) begin
                dout2_d = in_data;
                sel2_d  = C_SEL_HIGH;
            end else begin
                dout2_d = in_data;
                sel1_d  = C_SEL_HIGH;
            end
            cnt_d = (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    cnt_d   = 4'd0;
                    last_d  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    terr_d  = 1'b0;
`endif
                end
            end
            S_LOAD_A: begin
                if (accept && cnt_q == 4'd3) state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                if (accept && cnt_q == 4'd9) state_d = S_LOAD_X;
            end
            S_LOAD_X: begin
                if (last_q) begin
                    state_d = S_DONE;
                    last_d  = 1'b0;
                end else if (accept && cnt_q == 4'd11) begin
                    last_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SEQ_TIMEOUT_EN
        // Count consecutive in_valid=0 cycles while loading. The 255th
        // abandons the load without a done pulse.
        if (in_load) begin
            if (accept) begin
                idle_d = 8'd0;
            end else if (!in_valid) begin
                if (idle_q == 8'd254) begin
                    idle_d  = 8'd0;
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    last_d  = 1'b0;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
        end else begin
            idle_d = 8'd0;
        end
        timeout_err = terr_q;
`else
        timeout_err = 1'b0;
`endif
    end

    assign data_out1 = dout1_q;
    assign data_out2 = dout2_q;
    assign sel1      = sel1_q;
    assign sel2      = sel2_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_load_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_load_seq
// Purpose  : Directed testbench for matrix_load_seq. Each accepted word pushes
//            its expected slot to a scoreboard queue. Each presented word
//            (any select not idle) pops and compares. Control outputs are
//            checked every cycle against a small behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_load_seq;

    localparam logic [2:0] C_IDLE = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_ready;
    logic [15:0] data_out1;
    logic [15:0] data_out2;
    logic [2:0]  sel1;
    logic [2:0]  sel2;
    logic        busy;
    logic        done;
    logic        timeout_err;

    always #5 clk = ~clk;

    matrix_load_seq u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .data_out1   (data_out1),
        .data_out2   (data_out2),
        .sel1        (sel1),
        .sel2        (sel2),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        use1;
        logic [15:0] d;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model.
    // m_ph: 0 = none, 1 = word 11 just accepted, 2 = presentation cycle,
    //       3 = DONE cycle.
    bit   m_ready = 1'b0;
    int   m_cnt = 0;
    int   m_ph = 0;
    bit   m_terr = 1'b0;
    int   m_tmo = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic v, input logic [15:0] d);
        bit   acc;
        bit   pre_idle;
        bit   pre_load;
        exp_t e;
        start    = st;
        in_valid = v;
        in_data  = d;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        pre_idle = !m_ready && (m_ph == 0);
        pre_load = m_ready || (m_ph == 2);
        acc      = v && m_ready;
        if (acc) begin
            e.d    = d;
            e.s1   = C_IDLE;
            e.s2   = C_IDLE;
            e.use1 = 1'b0;
            if (m_cnt < 4) begin
                e.s1   = m_cnt[2:0];
                e.use1 = 1'b1;
            end else if (m_cnt < 10) begin
                e.s2 = 3'(m_cnt - 4);
            end else if (m_cnt == 10) begin
                e.s2 = 3'b111;
            end else begin
                e.s1 = 3'b111;
            end
            sbq.push_back(e);
            m_cnt++;
            if (m_cnt == 12) begin
                m_ready = 1'b0;
                m_ph    = 1;
                m_cnt   = 0;
            end
        end
`ifdef SEQ_TIMEOUT_EN
        if (pre_load) begin
            if (acc) m_tmo = 0;
            else if (!v) begin
                if (m_tmo == 254) begin
                    m_tmo   = 0;
                    m_ready = 1'b0;
                    m_ph    = 0;
                    m_terr  = 1'b1;
                end else begin
                    m_tmo++;
                end
            end
        end else begin
            m_tmo = 0;
        end
`else
        if (pre_load) m_tmo = 0;
`endif
        if (pre_idle && st) begin
            m_ready = 1'b1;
            m_cnt   = 0;
            m_terr  = 1'b0;
        end

        @(posedge clk);
        #1;

        if (m_ph == 3)      m_ph = 0;
        else if (m_ph == 2) m_ph = 3;
        else if (m_ph == 1) m_ph = 2;

        if (sel1 !== C_IDLE || sel2 !== C_IDLE) begin
            if (sbq.size() == 0) begin
                chk("sel1_unexpected", 32'(sel1), 32'(C_IDLE));
                chk("sel2_unexpected", 32'(sel2), 32'(C_IDLE));
            end else begin
                e = sbq.pop_front();
                chk("sel1", 32'(sel1), 32'(e.s1));
                chk("sel2", 32'(sel2), 32'(e.s2));
                if (e.use1) chk("data_out1", 32'(data_out1), 32'(e.d));
                else        chk("data_out2", 32'(data_out2), 32'(e.d));
            end
        end else begin
            chk("word_missing", 32'(sbq.size()), 32'd0);
        end
        chk("done", 32'(done), 32'(m_ph == 3));
        chk("busy", 32'(busy), 32'(m_ready || m_ph == 2 || m_ph == 3));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'd0;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        m_cnt   = 0;
        m_ph    = 0;
        m_terr  = 1'b0;
        m_tmo   = 0;
        sbq.delete();
        chk("rst_data_out1", 32'(data_out1), 32'd0);
        chk("rst_data_out2", 32'(data_out2), 32'd0);
        chk("rst_sel1", 32'(sel1), 32'(C_IDLE));
        chk("rst_sel2", 32'(sel2), 32'(C_IDLE));
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
    endtask

    // Feeds n words base, base+1, ... Inserts glen idle cycles after the
    // words numbered g1 and g2 (1-based), and raises start alongside word
    // index st_at.
    task automatic feed(input logic [15:0] base, input int n, input int g1,
                        input int g2, input int glen, input int st_at);
        for (int i = 0; i < n; i++) begin
            step(i == st_at, 1'b1, base + 16'(i));
            if (i + 1 == g1 || i + 1 == g2) begin
                for (int k = 0; k < glen; k++) step(1'b0, 1'b0, 16'hDEAD);
            end
        end
    endtask

    initial begin
        // Back-to-back load of 0x0001..0x000C.
        do_reset();
        step(1'b1, 1'b0, 16'd0);
        feed(16'h0001, 12, -1, -1, 0, -1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'd0);

        // The same stream with 3-cycle gaps after words 2 and 7.
        step(1'b1, 1'b0, 16'd0);
        feed(16'h0001, 12, 2, 7, 3, -1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'd0);

        // Reset after word 5, then a full reload of 0x0100..0x010B.
        step(1'b1, 1'b0, 16'd0);
        feed(16'h0050, 5, -1, -1, 0, -1);
        do_reset();
        step(1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd0);
        feed(16'h0100, 12, -1, -1, 0, -1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'd0);

        // start pulsed during LOAD_B and on the DONE cycle is ignored.
        step(1'b1, 1'b0, 16'd0);
        feed(16'h0A00, 12, -1, -1, 0, 6);
        step(1'b0, 1'b0, 16'd0);
        step(1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'd0);

        // Random data with random valid gaps.
        step(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 12; i++) begin
            while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 16'(i));
            step(1'b0, 1'b1, 16'($urandom));
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'd0);

        // in_valid held low after word 4. With the timeout built, the load
        // aborts. Without it, the block keeps waiting.
        step(1'b1, 1'b0, 16'd0);
        feed(16'h0C00, 4, -1, -1, 0, -1);
        for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 16'd0);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_load_seq.md
MATRIX_LOAD_SEQ -- requirements
Module: matrix_load_seq

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  begins one 12-word operand load when sampled high in IDLE.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  16  upstream operand word.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 data_out1  output  16  operand word to the demux first data input (square-matrix slots).
REQ-009 data_out2  output  16  operand word to the demux second data input (other slots).
REQ-010 sel1  output  3  demux first select code.
REQ-011 sel2  output  3  demux second select code.
REQ-012 busy  output  1  high from load start until DONE is exited.
REQ-013 done  output  1  one-cycle pulse after the 12th word is presented.
REQ-014 timeout_err  output  1  sticky timeout flag (tied 0 when SEQ_TIMEOUT_EN is undefined).

Function
REQ-015 States SHALL be IDLE, LOAD_A, LOAD_B, LOAD_X, DONE; the word counter is 4 bits, range 0..11.
REQ-016 IDLE->LOAD_A on start=1; start SHALL be ignored in all other states.
REQ-017 in_ready SHALL be 1 only in LOAD_A/LOAD_B/LOAD_X; a word is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-018 Accepted words 0..3 SHALL be driven on data_out1 with sel1=0..3 and sel2=3'b110.
REQ-019 Accepted words 4..9 SHALL be driven on data_out2 with sel2=0..5 and sel1=3'b110.
REQ-020 Word 10 SHALL be driven on data_out2 with sel2=3'b111 and sel1=3'b110.
REQ-021 Word 11 SHALL be driven on data_out2 with sel1=3'b111 and sel2=3'b110, because the sink routes sel1=7 from its second data input.
REQ-022 Presentation latency SHALL be 1 cycle: data and select are registered on the accept edge and held for exactly one cycle.
REQ-023 After that cycle, sel1/sel2 SHALL return to the idle code 3'b110; data_out1/data_out2 hold their last value.
REQ-024 Transitions: LOAD_A->LOAD_B after word 3, LOAD_B->LOAD_X after word 9, LOAD_X->DONE after word 11.
REQ-025 DONE SHALL last one cycle with done=1 and then go to IDLE; busy=1 in LOAD_* and DONE.
REQ-026 in_valid=0 gaps SHALL stall the sequence with no word skipped or repeated; sel codes stay 3'b110 during gaps.
REQ-027 Back-to-back accepts SHALL present consecutive words on consecutive cycles.
REQ-028 start asserted in the same cycle as the DONE pulse SHALL be ignored; it is honoured only from IDLE.

Reset
REQ-029 On rst_n=0 at a rising edge, all outputs SHALL reset: data_out1=0, data_out2=0, sel1=sel2=3'b110, in_ready=0, busy=0, done=0, timeout_err=0; state SHALL reset to IDLE and the counter to 0.
REQ-030 Reset mid-load SHALL abandon the load; no select other than 3'b110 SHALL appear the cycle after reset.

Configuration
REQ-031 Macro SEQ_TIMEOUT_EN defined: an 8-bit idle counter runs in LOAD_* while in_valid=0 and clears on accept.
REQ-032 On count 255, the block SHALL set timeout_err (sticky until reset or next start), return to IDLE, and emit no done.
REQ-033 SEQ_TIMEOUT_EN undefined: no counter is built, timeout_err=0, and the block waits indefinitely.

Verification
REQ-034 Reset then start with 12 back-to-back words 0x0001..0x000C -> sel1=0..3 with data_out1=0x0001..0x0004; sel2=0..5 with data_out2=0x0005..0x000A; sel2=7/0x000B; sel1=7/0x000C; done pulses on the cycle after 0x000C.
REQ-035 Same stream with in_valid low for 3 cycles after words 2 and 7 -> identical slot mapping and 6-cycle-longer load; sel=3'b110 during gaps.
REQ-036 rst_n low after word 5 -> all outputs at reset values next cycle; a new start with 0x0100..0x010B loads fully and correctly.
REQ-037 start pulsed during LOAD_B and on the DONE cycle -> no effect; exactly one done pulse.
REQ-038 SEQ_TIMEOUT_EN defined, in_valid held low 255 cycles after word 4 -> timeout_err=1, busy=0, no done; macro undefined -> still waiting, timeout_err=0.
